// File: rtl/div_ctrl.sv
// div_ctrl: run-time controller for the even-ratio clock divider path.
// Validates divisors, applies them on period boundaries, starts/stops glitch-free.
module div_ctrl #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             busy,
   output logic [CNT_W-1:0] cur_div
);

   localparam logic [CNT_W-1:0] DEF_V = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-2:0] ONE_H = {{(CNT_W-2){1'b0}}, 1'b1};

   if ((DEF_DIV % 2) != 0 || DEF_DIV < 2 ||
       DEF_DIV > (2 ** CNT_W) - 2) begin : g_bad_def
      $error("div_ctrl: illegal DEF_DIV %0d", DEF_DIV);
   end

   typedef enum logic [1:0] {
      S_OFF,
      S_RUN,
      S_STOP
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-2:0] cnt, cnt_d;
   logic [CNT_W-2:0] h, h_m1;
   logic             clk_d;
   logic [CNT_W-1:0] cur_d;
   logic [CNT_W-1:0] pend_div, pend_d;
   logic             pend_vld, pvld_d;
   logic             err_d;
   logic             wrap;
   logic             legal;
   logic             xfer;
   logic             apply;

   assign h         = cur_div[CNT_W-1:1];
   assign h_m1      = h - ONE_H;
   assign wrap      = (cnt == h_m1);
   assign legal     = ~cfg_div[0] & (|cfg_div[CNT_W-1:1]);
   assign cfg_ready = ~pend_vld;
   assign xfer      = cfg_valid & cfg_ready;
   assign busy      = (state != S_OFF);

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state    <= S_OFF;
         cnt      <= '0;
         clk_out  <= 1'b0;
         cur_div  <= DEF_V;
         pend_div <= '0;
         pend_vld <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         clk_out  <= clk_d;
         cur_div  <= cur_d;
         pend_div <= pend_d;
         pend_vld <= pvld_d;
         cfg_err  <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      clk_d   = clk_out;
      cur_d   = cur_div;
      pend_d  = pend_div;
      pvld_d  = pend_vld;
      err_d   = xfer & ~legal;
      apply   = 1'b0;

      unique case (state)
         S_OFF: begin
            cnt_d = '0;
            clk_d = 1'b0;
            // a divisor parked while stopping is taken once idle
            apply = pend_vld;
            if (en) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (!en && !clk_out) begin
               state_d = S_OFF;
               cnt_d   = '0;
               clk_d   = 1'b0;
               apply   = pend_vld;
            end else if (wrap) begin
               cnt_d = '0;
               clk_d = ~clk_out;
               if (clk_out) begin
                  apply = pend_vld;
                  // high phase just completed: no need to linger in STOP
                  if (!en) begin
                     state_d = S_OFF;
                  end
               end
            end else begin
               cnt_d = cnt + ONE_H;
               if (!en) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (wrap) begin
               state_d = S_OFF;
               cnt_d   = '0;
               clk_d   = 1'b0;
               apply   = pend_vld;
            end else begin
               cnt_d = cnt + ONE_H;
            end
         end
         default: begin
            state_d = S_OFF;
            cnt_d   = '0;
            clk_d   = 1'b0;
         end
      endcase

      if (apply) begin
         cur_d  = pend_div;
         pvld_d = 1'b0;
      end

      if (xfer && legal) begin
         if (state == S_OFF) begin
            cur_d = cfg_div;
         end else begin
            pend_d = cfg_div;
            pvld_d = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl with a per-cycle expectation queue.
// Expected clk_out/cfg_err/busy/cur_div are queued as stimulus is driven.
module tb_div_ctrl;

   logic       clk_in;
   logic       rst;
   logic       en;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic       cfg_err;
   logic       clk_out;
   logic       busy;
   logic [7:0] cur_div;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic       clk;
      logic       err;
      logic       bsy;
      logic [7:0] div;
   } exp_t;

   exp_t sb_q[$];

   div_ctrl #(
      .CNT_W  (8),
      .DEF_DIV(8)
   ) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (en),
      .cfg_valid(cfg_valid),
      .cfg_div  (cfg_div),
      .cfg_ready(cfg_ready),
      .cfg_err  (cfg_err),
      .clk_out  (clk_out),
      .busy     (busy),
      .cur_div  (cur_div)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int n, input logic c, input logic e,
                       input logic b, input logic [7:0] d);
      exp_t x;
      x = '{clk: c, err: e, bsy: b, div: d};
      for (int i = 0; i < n; i++) sb_q.push_back(x);
   endtask

   task automatic run(input string tag);
      exp_t e;
      exp_t o;
      while (sb_q.size() > 0) begin
         tick();
         e = sb_q.pop_front();
         o = '{clk: clk_out, err: cfg_err, bsy: busy, div: cur_div};
         chk(tag, 32'(o), 32'(e));
      end
   endtask

   logic [7:0] bad_div [3];

   initial begin
      bad_div = '{8'd5, 8'd0, 8'd1};
      rst = 1'b1;
      en = 1'b0;
      cfg_valid = 1'b0;
      cfg_div = '0;
      repeat (2) @(posedge clk_in);
      #3;
      chk("rst_clk", 32'(clk_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_div", 32'(cur_div), 32'd8);
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_err", 32'(cfg_err), 32'd0);
      rst = 1'b0;

      // start at default divisor 8
      en = 1'b1;
      push(4, 0, 0, 1, 8);
      push(4, 1, 0, 1, 8);
      push(4, 0, 0, 1, 8);
      push(2, 1, 0, 1, 8);
      run("t1_wave8");

      // new divisor 4 mid-high
      cfg_valid = 1'b1;
      cfg_div = 8'd4;
      chk("t2_ready_pre", 32'(cfg_ready), 32'd1);
      push(1, 1, 0, 1, 8);
      run("t2_accept");
      cfg_valid = 1'b0;
      chk("t2_ready_pend", 32'(cfg_ready), 32'd0);
      push(1, 1, 0, 1, 8);
      push(2, 0, 0, 1, 4);
      push(2, 1, 0, 1, 4);
      push(2, 0, 0, 1, 4);
      push(2, 1, 0, 1, 4);
      run("t2_wave4");
      chk("t2_ready_post", 32'(cfg_ready), 32'd1);

      // illegal divisors
      for (int i = 0; i < 3; i++) begin
         cfg_valid = 1'b1;
         cfg_div = bad_div[i];
         chk("t3_ready", 32'(cfg_ready), 32'd1);
         push(1, i[0], 1, 1, 4);
         run("t3_err");
         cfg_valid = 1'b0;
         push(1, i[0], 0, 1, 4);
         run("t3_idle");
      end

      // back to divisor 8
      cfg_valid = 1'b1;
      cfg_div = 8'd8;
      push(1, 1, 0, 1, 4);
      run("t3b_accept");
      cfg_valid = 1'b0;
      push(1, 1, 0, 1, 4);
      push(4, 0, 0, 1, 8);
      push(1, 1, 0, 1, 8);
      run("t3b_wave");

      // stop during high, en re-asserted in STOP, stop during low
      en = 1'b0;
      push(1, 1, 0, 1, 8);
      run("t4_stop");
      en = 1'b1;
      push(2, 1, 0, 1, 8);
      push(1, 0, 0, 0, 8);
      push(1, 0, 0, 1, 8);
      run("t4_restart");
      en = 1'b0;
      push(2, 0, 0, 0, 8);
      run("t4_lowstop");

      // reset mid-high with pending divisor 6
      en = 1'b1;
      push(4, 0, 0, 1, 8);
      push(1, 1, 0, 1, 8);
      run("t5_run");
      cfg_valid = 1'b1;
      cfg_div = 8'd6;
      push(1, 1, 0, 1, 8);
      run("t5_pend");
      cfg_valid = 1'b0;
      chk("t5_ready_pend", 32'(cfg_ready), 32'd0);
      #2;
      rst = 1'b1;
      en = 1'b0;
      #1;
      chk("t5_rst_clk", 32'(clk_out), 32'd0);
      chk("t5_rst_busy", 32'(busy), 32'd0);
      chk("t5_rst_div", 32'(cur_div), 32'd8);
      chk("t5_rst_ready", 32'(cfg_ready), 32'd1);
      @(posedge clk_in);
      #3;
      rst = 1'b0;
      chk("t5_ready_rel", 32'(cfg_ready), 32'd1);
      en = 1'b1;
      push(4, 0, 0, 1, 8);
      push(4, 1, 0, 1, 8);
      push(4, 0, 0, 1, 8);
      run("t5_wave8");
      en = 1'b0;
      push(1, 0, 0, 0, 8);
      run("t5_off");

      // divisor 2
      cfg_valid = 1'b1;
      cfg_div = 8'd2;
      push(1, 0, 0, 0, 2);
      run("t6_cfg");
      cfg_valid = 1'b0;
      en = 1'b1;
      push(1, 0, 0, 1, 2);
      push(1, 1, 0, 1, 2);
      push(1, 0, 0, 1, 2);
      push(1, 1, 0, 1, 2);
      run("t6_wave2");
      en = 1'b0;
      push(2, 0, 0, 0, 2);
      run("t6_off");

      // divisor and en on the same edge in OFF
      cfg_valid = 1'b1;
      cfg_div = 8'd6;
      en = 1'b1;
      push(1, 0, 0, 1, 6);
      run("t7_start");
      cfg_valid = 1'b0;
      push(2, 0, 0, 1, 6);
      push(3, 1, 0, 1, 6);
      push(1, 0, 0, 1, 6);
      run("t7_wave6");
      en = 1'b0;
      push(1, 0, 0, 0, 6);
      run("t7_off");

      // largest legal and odd upper values
      cfg_valid = 1'b1;
      cfg_div = 8'd254;
      push(1, 0, 0, 0, 254);
      run("t8_max");
      cfg_div = 8'd255;
      push(1, 0, 1, 0, 254);
      run("t8_odd");
      cfg_valid = 1'b0;
      push(1, 0, 0, 0, 254);
      run("t8_idle");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
